// File: rtl/mcp_pkg.sv
// Shared constants and helpers for the multi-channel change-pulse detector.
package mcp_pkg;

    localparam int MODE_ANY  = 0;
    localparam int MODE_RISE = 1;
    localparam int MODE_FALL = 2;

    // Stretch counter width: wide enough to hold PULSE_LEN-1.
    function automatic int cnt_width(input int pulse_len);
        return (pulse_len < 1) ? 1 : $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/change_pulse_ch.sv
// One monitored channel: history register, arm bit, stretch counter,
// stretched pulse and sticky flag. o_det is the unregistered event strobe.
module change_pulse_ch
    import mcp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PULSE_LEN  = 1,
    parameter int MODE       = MODE_ANY,
    parameter int ARM_ON_1ST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  logic              i_clr,
    output logic              o_pulse,
    output logic              o_flag,
    output logic              o_det
);

    localparam int            CW     = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);

    logic [DATA_W-1:0] r_prev;
    logic              r_armed;
    logic [CW-1:0]     r_cnt;
    logic              r_pulse;
    logic              r_flag;
    logic              w_cond;
    logic              w_det;

    always_comb begin
        w_cond = 1'b0;
        case (MODE)
            MODE_RISE: w_cond = (i_data > r_prev);
            MODE_FALL: w_cond = (i_data < r_prev);
            default:   w_cond = (i_data != r_prev);
        endcase
    end

    assign w_det = i_en & r_armed & w_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '0;
            r_armed <= (ARM_ON_1ST == 0);
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            // History tracks the input even while disabled, so re-enabling
            // never compares against a stale value.
            r_prev  <= i_data;
            r_armed <= 1'b1;

            if (!i_en) begin
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else if (w_det) begin
                r_cnt   <= RELOAD;
                r_pulse <= 1'b1;
            end else if (r_cnt != '0) begin
                r_cnt   <= r_cnt - 1'b1;
            end else begin
                r_pulse <= 1'b0;
            end

            if (w_det)
                r_flag <= 1'b1;
            else if (i_clr)
                r_flag <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;
    assign o_det   = w_det;

endmodule

// File: rtl/multi_change_pulse.sv
// NUM_CH independent change detectors with stretched pulses, sticky flags
// and a registered OR of all per-cycle detect events.
module multi_change_pulse
    import mcp_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int PULSE_LEN  = 1,
    parameter int MODE       = MODE_ANY,
    parameter int ARM_ON_1ST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        flag_clr,
    output logic [NUM_CH-1:0]        pulse,
    output logic [NUM_CH-1:0]        flag,
    output logic                     any_pulse
);

    logic [NUM_CH-1:0] w_det;
    logic              r_any_pulse;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        change_pulse_ch #(
            .DATA_W     (DATA_W),
            .PULSE_LEN  (PULSE_LEN),
            .MODE       (MODE),
            .ARM_ON_1ST (ARM_ON_1ST)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_data  (data_in[g*DATA_W +: DATA_W]),
            .i_en    (ch_en[g]),
            .i_clr   (flag_clr[g]),
            .o_pulse (pulse[g]),
            .o_flag  (flag[g]),
            .o_det   (w_det[g])
        );
    end

    // Unstretched: one cycle per cycle in which any channel detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_any_pulse <= 1'b0;
        else
            r_any_pulse <= |w_det;
    end

    assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_multi_change_pulse.sv
// Four differently-parameterised instances share one randomized stimulus
// stream; a timeline reference model feeds a scoreboard drained by a monitor.
module tb_multi_change_pulse;

    localparam int NDUT = 4;
    localparam int PL_T   [NDUT] = '{1, 4, 2, 3};
    localparam int MODE_T [NDUT] = '{0, 0, 1, 2};
    localparam int ARM_T  [NDUT] = '{1, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic [3:0]  ch_en;
    logic [3:0]  flag_clr;
    logic [3:0]  pulse_o [NDUT];
    logic [3:0]  flag_o  [NDUT];
    logic        any_o   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        multi_change_pulse #(
            .NUM_CH     (4),
            .DATA_W     (8),
            .PULSE_LEN  (PL_T[g]),
            .MODE       (MODE_T[g]),
            .ARM_ON_1ST (ARM_T[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .data_in   (data_in),
            .ch_en     (ch_en),
            .flag_clr  (flag_clr),
            .pulse     (pulse_o[g]),
            .flag      (flag_o[g]),
            .any_pulse (any_o[g])
        );
    end

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] f;
        logic [3:0]  a;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: a pulse is high at edge t iff the latest event on
    // that channel happened at e with t-e < PULSE_LEN and no disabled edge
    // occurred in (e, t].
    logic [7:0] m_prev  [NDUT][4];
    bit         m_armed [NDUT][4];
    int         m_ldet  [NDUT][4];
    int         m_ldis  [NDUT][4];
    bit         m_flag  [NDUT][4];
    int         t = 0;

    function automatic void model_reset();
        for (int d = 0; d < NDUT; d++)
            for (int c = 0; c < 4; c++) begin
                m_prev[d][c]  = 8'h00;
                m_armed[d][c] = (ARM_T[d] == 0);
                m_ldet[d][c]  = -1;
                m_ldis[d][c]  = -1;
                m_flag[d][c]  = 1'b0;
            end
    endfunction

    function automatic exp_t model_edge();
        exp_t e;
        e = '0;
        e.cyc = t;
        for (int d = 0; d < NDUT; d++)
            for (int c = 0; c < 4; c++) begin
                logic [7:0] v;
                bit cond, det, pl;
                v = data_in[c*8 +: 8];
                case (MODE_T[d])
                    1:       cond = (v > m_prev[d][c]);
                    2:       cond = (v < m_prev[d][c]);
                    default: cond = (v != m_prev[d][c]);
                endcase
                det = ch_en[c] && m_armed[d][c] && cond;
                if (det)       m_ldet[d][c] = t;
                if (!ch_en[c]) m_ldis[d][c] = t;
                pl = (m_ldet[d][c] >= 0) && (m_ldet[d][c] > m_ldis[d][c]) &&
                     ((t - m_ldet[d][c]) < PL_T[d]);
                if (det)              m_flag[d][c] = 1'b1;
                else if (flag_clr[c]) m_flag[d][c] = 1'b0;
                e.p[d*4 + c] = pl;
                e.f[d*4 + c] = m_flag[d][c];
                if (det) e.a[d] = 1'b1;
                m_prev[d][c]  = v;
                m_armed[d][c] = 1'b1;
            end
        t++;
        return e;
    endfunction

    task automatic drive(input logic [31:0] d, input logic [3:0] en, input logic [3:0] clr);
        @(negedge clk);
        rst_n    = 1'b1;
        data_in  = d;
        ch_en    = en;
        flag_clr = clr;
        sb.push_back(model_edge());
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (pulse_o[d] !== 4'h0 || flag_o[d] !== 4'h0 || any_o[d] !== 1'b0) begin
                n_err++;
                $display("FAIL %s dut%0d: got p=%h f=%h a=%b, need all 0",
                         tag, d, pulse_o[d], flag_o[d], any_o[d]);
            end
        end
    endtask

    // Assert reset in the middle of the low clock phase; outputs must drop
    // without waiting for an edge. Release happens in the next drive().
    task automatic reset_mid();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    n_cmp++;
                    if (pulse_o[d] !== e.p[d*4 +: 4] || flag_o[d] !== e.f[d*4 +: 4] ||
                        any_o[d] !== e.a[d]) begin
                        n_err++;
                        $display("FAIL cyc%0d dut%0d: got p=%h f=%h a=%b, exp p=%h f=%h a=%b",
                                 e.cyc, d, pulse_o[d], flag_o[d], any_o[d],
                                 e.p[d*4 +: 4], e.f[d*4 +: 4], e.a[d]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] w4(input logic [7:0] b3, b2, b1, b0);
        return {b3, b2, b1, b0};
    endfunction

    initial begin : stim
        logic [31:0] cur;
        logic [3:0]  en, clr;
        rst_n    = 1'b0;
        cur      = w4(8'h00, 8'h00, 8'h10, 8'h5A);
        data_in  = cur;
        ch_en    = 4'hF;
        flag_clr = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");

        // First sample after release, then a single-step change on ch0.
        drive(cur, 4'hF, 4'h0);
        cur[7:0] = 8'h5B;
        drive(cur, 4'hF, 4'h0);
        repeat (3) drive(cur, 4'hF, 4'h0);

        // Retrigger two cycles into a stretched pulse.
        cur[7:0] = 8'h5C; drive(cur, 4'hF, 4'h0);
        drive(cur, 4'hF, 4'h0);
        cur[7:0] = 8'h5D; drive(cur, 4'hF, 4'h0);
        repeat (6) drive(cur, 4'hF, 4'h0);

        // Direction modes on ch3, including wraparound values.
        foreach (cur[i]) ;
        cur[31:24] = 8'h10; drive(cur, 4'hF, 4'h0);
        cur[31:24] = 8'h20; drive(cur, 4'hF, 4'h0);
        cur[31:24] = 8'h05; drive(cur, 4'hF, 4'h0);
        cur[31:24] = 8'hFF; drive(cur, 4'hF, 4'h0);
        cur[31:24] = 8'h00; drive(cur, 4'hF, 4'h0);
        repeat (3) drive(cur, 4'hF, 4'h0);

        // ch2 disabled while toggling, then re-enabled with static data.
        cur[23:16] = 8'h11; drive(cur, 4'b1011, 4'h0);
        cur[23:16] = 8'h22; drive(cur, 4'b1011, 4'h0);
        cur[23:16] = 8'h11; drive(cur, 4'b1011, 4'h0);
        repeat (3) drive(cur, 4'hF, 4'h0);

        // Flag clear coincident with an event, then a plain clear.
        cur[15:8] = 8'h33; drive(cur, 4'hF, 4'b0010);
        drive(cur, 4'hF, 4'b0010);
        drive(cur, 4'hF, 4'h0);

        // Reset during a stretched pulse, then all channels change at once.
        cur[7:0] = 8'h70; drive(cur, 4'hF, 4'h0);
        reset_mid();
        drive(cur, 4'hF, 4'h0);
        cur = cur ^ 32'h8181_8181;
        drive(cur, 4'hF, 4'h0);
        repeat (4) drive(cur, 4'hF, 4'h0);

        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < 4; c++) begin
                case ($urandom_range(0, 5))
                    0, 1: cur[c*8 +: 8] = 8'($urandom);
                    2:    cur[c*8 +: 8] = cur[c*8 +: 8] + 8'd1;
                    3:    cur[c*8 +: 8] = cur[c*8 +: 8] - 8'd1;
                    default: ;
                endcase
                en[c]  = ($urandom_range(0, 7) != 0);
                clr[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 63) == 0) reset_mid();
            drive(cur, en, clr);
        end

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
